// File: rtl/seviye_hesaplayici.sv
// Heap-indexed binary tree node-level calculator: walks the 1-based working value
// toward the root one shift per clock and reports level, in-level offset and parent.
module seviye_hesaplayici #(
  parameter int IDX_W     = 4,
  parameter int LVL_W     = 3,
  parameter int ONE_BASED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] dugum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LVL_W-1:0] dugumun_seviyesi,
  output logic [IDX_W-1:0] konum,
  output logic [IDX_W-1:0] ebeveyn,
  output logic             kok,
  output logic             hata
);

  typedef enum logic [1:0] {IDLE, WALK, ERR_DONE, DONE} state_t;

  state_t           r_state;
  logic [IDX_W:0]   r_w;
  logic [IDX_W-1:0] r_w0;
  logic [IDX_W-1:0] r_par;
  logic [LVL_W-1:0] r_cnt;

  logic [IDX_W:0]   w_w_in;
  logic [IDX_W-1:0] w_dm1;
  logic [IDX_W-1:0] w_par;
  logic             w_illegal;
  logic [IDX_W-1:0] w_konum;

  // Working value is always 1-based so the root is w==1 for both numberings.
  assign w_w_in    = {1'b0, dugum} + ((ONE_BASED != 0) ? '0 : (IDX_W+1)'(1));
  assign w_dm1     = dugum - IDX_W'(1);
  assign w_illegal = (ONE_BASED != 0) && (dugum == '0);

  always_comb begin
    w_par = '0;
    if (ONE_BASED != 0)
      w_par = (dugum == IDX_W'(1)) ? IDX_W'(1) : (dugum >> 1);
    else
      w_par = (dugum == '0) ? '0 : (w_dm1 >> 1);
  end

  // Only the low IDX_W bits matter: the offset is always below 2^IDX_W, and for
  // w = 2^IDX_W both operands wrap to zero.
  assign w_konum  = r_w0 - (IDX_W'(1) << r_cnt);
  assign in_ready = (r_state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_w              <= '0;
      r_w0             <= '0;
      r_par            <= '0;
      r_cnt            <= '0;
      out_valid        <= 1'b0;
      dugumun_seviyesi <= '0;
      konum            <= '0;
      ebeveyn          <= '0;
      kok              <= 1'b0;
      hata             <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_w     <= w_w_in;
            r_w0    <= w_w_in[IDX_W-1:0];
            r_par   <= w_par;
            r_cnt   <= '0;
            r_state <= w_illegal ? ERR_DONE : WALK;
          end
        end
        WALK: begin
          if (r_w == (IDX_W+1)'(1)) begin
            dugumun_seviyesi <= r_cnt;
            konum            <= w_konum;
            ebeveyn          <= r_par;
            kok              <= (r_cnt == '0);
            hata             <= 1'b0;
            out_valid        <= 1'b1;
            r_state          <= DONE;
          end else begin
            r_w   <= r_w >> 1;
            r_cnt <= r_cnt + LVL_W'(1);
          end
        end
        ERR_DONE: begin
          dugumun_seviyesi <= '0;
          konum            <= '0;
          ebeveyn          <= '0;
          kok              <= 1'b0;
          hata             <= 1'b1;
          out_valid        <= 1'b1;
          r_state          <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seviye_hesaplayici.sv
// Bench for seviye_hesaplayici: three instances (4-bit 0-based, 4-bit 1-based,
// 8-bit 0-based) driven from a vector table, hand sequences and random requests.
module tb_seviye_hesaplayici;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0] in_valid, out_ready;
  logic [2:0] in_ready, out_valid, kok, hata;
  logic [3:0] d0, d1;
  logic [7:0] d2;
  logic [2:0] l0, l1;
  logic [3:0] l2;
  logic [3:0] k0, k1, p0, p1;
  logic [7:0] k2, p2;

  seviye_hesaplayici #(.IDX_W(4), .LVL_W(3), .ONE_BASED(0)) u_z4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .dugum(d0), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .dugumun_seviyesi(l0), .konum(k0), .ebeveyn(p0), .kok(kok[0]), .hata(hata[0]));

  seviye_hesaplayici #(.IDX_W(4), .LVL_W(3), .ONE_BASED(1)) u_o4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .dugum(d1), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .dugumun_seviyesi(l1), .konum(k1), .ebeveyn(p1), .kok(kok[1]), .hata(hata[1]));

  seviye_hesaplayici #(.IDX_W(8), .LVL_W(4), .ONE_BASED(0)) u_z8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .dugum(d2), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .dugumun_seviyesi(l2), .konum(k2), .ebeveyn(p2), .kok(kok[2]), .hata(hata[2]));

  int tests = 0;
  int fails = 0;

  typedef struct {
    int s; int d; int lv; int kn; int pr; int kk; int hh; int lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic get_out(input int s, output int lv, output int kn, output int pr,
                         output int kk, output int hh);
    case (s)
      0:       begin lv = int'(l0); kn = int'(k0); pr = int'(p0); end
      1:       begin lv = int'(l1); kn = int'(k1); pr = int'(p1); end
      default: begin lv = int'(l2); kn = int'(k2); pr = int'(p2); end
    endcase
    kk = int'(kok[s]);
    hh = int'(hata[s]);
  endtask

  task automatic set_d(input int s, input int d);
    case (s)
      0:       d0 = 4'(d);
      1:       d1 = 4'(d);
      default: d2 = 8'(d);
    endcase
  endtask

  // Reference: level is the position of the top set bit of the 1-based index.
  task automatic model(input int s, input int d, output int lv, output int kn,
                       output int pr, output int kk, output int hh, output int lat);
    bit ob;
    int w;
    ob = (s == 1);
    w  = ob ? d : d + 1;
    if (ob && d == 0) begin
      lv = 0; kn = 0; pr = 0; kk = 0; hh = 1; lat = 1;
    end else begin
      lv  = $clog2(w + 1) - 1;
      kn  = w - (1 << lv);
      if (ob) pr = (d == 1) ? 1 : d / 2;
      else    pr = (d == 0) ? 0 : (d - 1) / 2;
      kk  = (lv == 0) ? 1 : 0;
      hh  = 0;
      lat = lv + 1;
    end
  endtask

  // Issues one request from a falling edge; returns at the falling edge where
  // out_valid is first seen, with lat = rising edges from accept to that point.
  task automatic do_req(input int s, input int d, output int lat, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!in_ready[s] && n < 50) begin @(negedge clk); n++; end
    if (!in_ready[s]) begin check("in_ready_timeout", 0, 1); return; end
    set_d(s, d);
    in_valid[s] = 1'b1;
    @(posedge clk);
    #1 in_valid[s] = 1'b0;
    set_d(s, $urandom);
    do begin
      @(negedge clk);
      if (!out_valid[s]) lat++;
    end while (!out_valid[s] && lat < 50);
    if (!out_valid[s]) begin check("out_valid_timeout", 0, 1); return; end
    ok = 1'b1;
  endtask

  task automatic handoff(input int s);
    out_ready[s] = 1'b1;
    @(posedge clk);
    #1 out_ready[s] = 1'b0;
  endtask

  task automatic run_check(input string tag, input int s, input int d, input int elv,
                           input int ekn, input int epr, input int ekk, input int ehh,
                           input int elat);
    int lat, lv, kn, pr, kk, hh;
    bit ok;
    do_req(s, d, lat, ok);
    if (!ok) return;
    get_out(s, lv, kn, pr, kk, hh);
    check({tag, ".level"},   lv,  elv);
    check({tag, ".konum"},   kn,  ekn);
    check({tag, ".ebeveyn"}, pr,  epr);
    check({tag, ".kok"},     kk,  ekk);
    check({tag, ".hata"},    hh,  ehh);
    check({tag, ".latency"}, lat, elat);
    handoff(s);
  endtask

  vec_t vecs[$];

  initial begin
    int lv, kn, pr, kk, hh, lat;
    int slv, skn, spr, skk, shh;
    bit ok;

    vecs.push_back('{0, 0,   0, 0,  0,   1, 0, 1});
    vecs.push_back('{0, 6,   2, 3,  2,   0, 0, 3});
    vecs.push_back('{0, 15,  4, 0,  7,   0, 0, 5});
    vecs.push_back('{1, 0,   0, 0,  0,   0, 1, 1});
    vecs.push_back('{1, 9,   3, 1,  4,   0, 0, 4});
    vecs.push_back('{1, 1,   0, 0,  1,   1, 0, 1});
    vecs.push_back('{1, 15,  3, 7,  7,   0, 0, 4});
    vecs.push_back('{2, 200, 7, 73, 99,  0, 0, 8});
    vecs.push_back('{2, 255, 8, 0,  127, 0, 0, 9});
    vecs.push_back('{2, 1,   1, 0,  0,   0, 0, 2});

    rst = 1'b1; in_valid = '0; out_ready = '0; d0 = '0; d1 = '0; d2 = '0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      get_out(s, lv, kn, pr, kk, hh);
      check("reset.out_valid", int'(out_valid[s]), 0);
      check("reset.in_ready",  int'(in_ready[s]),  0);
      check("reset.fields",    lv | kn | pr | kk | hh, 0);
    end
    rst = 1'b0;

    foreach (vecs[i])
      run_check($sformatf("vec%0d", i), vecs[i].s, vecs[i].d, vecs[i].lv, vecs[i].kn,
                vecs[i].pr, vecs[i].kk, vecs[i].hh, vecs[i].lat);

    // Backpressure: result held for 4 cycles while a stray request is offered.
    do_req(0, 5, lat, ok);
    if (ok) begin
      get_out(0, slv, skn, spr, skk, shh);
      check("bp.level", slv, 2);
      check("bp.konum", skn, 2);
      check("bp.ebeveyn", spr, 2);
      for (int i = 0; i < 4; i++) begin
        in_valid[0] = (i == 1);
        d0 = 4'd9;
        @(negedge clk);
        get_out(0, lv, kn, pr, kk, hh);
        check("bp.out_valid", int'(out_valid[0]), 1);
        check("bp.in_ready",  int'(in_ready[0]),  0);
        check("bp.stable",    int'({lv == slv, kn == skn, pr == spr, kk == skk, hh == shh}), 31);
      end
      in_valid[0] = 1'b0;
      handoff(0);
      @(negedge clk);
      check("bp.after_out_valid", int'(out_valid[0]), 0);
      check("bp.after_in_ready",  int'(in_ready[0]),  1);
      repeat (3) @(negedge clk);
      check("bp.stray_ignored", int'(out_valid[0]), 0);
    end

    // Reset during the second WALK cycle of dugum=14 aborts the request.
    @(negedge clk);
    d0 = 4'd14;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    get_out(0, lv, kn, pr, kk, hh);
    check("rstwalk.out_valid", int'(out_valid[0]), 0);
    check("rstwalk.fields",    lv | kn | pr | kk | hh, 0);
    check("rstwalk.in_ready",  int'(in_ready[0]), 1);
    repeat (6) @(negedge clk);
    check("rstwalk.no_stale",  int'(out_valid[0]), 0);
    run_check("rstwalk.next", 0, 3, 2, 0, 1, 0, 0, 3);

    // Random requests against the reference model.
    for (int i = 0; i < 80; i++) begin
      int s, d;
      int elv, ekn, epr, ekk, ehh, elat;
      s = $urandom_range(0, 2);
      d = (s == 2) ? $urandom_range(0, 255) : $urandom_range(0, 15);
      model(s, d, elv, ekn, epr, ekk, ehh, elat);
      run_check($sformatf("rnd%0d_s%0d_d%0d", i, s, d), s, d, elv, ekn, epr, ekk, ehh, elat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
